// File: rtl/march_bist_if.sv
// SRAM-side bus of the March C- BIST controller.
// Read data is registered in the SRAM: it is valid the cycle after the address.
interface march_bist_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 4
);
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_we;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;
    logic              bist_active;

    modport master (
        output sram_addr,
        output sram_we,
        output sram_wdata,
        output bist_active,
        input  sram_rdata
    );

    modport slave (
        input  sram_addr,
        input  sram_we,
        input  sram_wdata,
        input  bist_active,
        output sram_rdata
    );
endinterface

// File: rtl/march_bist_controller.sv
// March C- sequencer for a single-port SRAM: drives one operation per clock,
// checks read data one cycle later and keeps pass/fail and first-failure diagnostics.
module march_bist_controller #(
    parameter int unsigned       ADDR_W = 8,
    parameter int unsigned       DATA_W = 4,
    parameter logic [DATA_W-1:0] BG     = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    march_bist_if.master      sram,
    output logic              busy,
    output logic              done,
    output logic              go_nogo,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_act,
    output logic [2:0]        fail_elem,
    output logic [7:0]        err_count,
    output logic [1:0]        dbg_state
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    logic [1:0]        state_q, state_d;
    logic [2:0]        elem_q, elem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              phase_q, phase_d;
    logic              pipe_vld_q, pipe_vld_d;
    logic [DATA_W-1:0] pipe_exp_q, pipe_exp_d;
    logic [ADDR_W-1:0] pipe_addr_q, pipe_addr_d;
    logic [2:0]        pipe_elem_q, pipe_elem_d;
    logic              done_q, done_d;
    logic              go_q, go_d;
    logic [7:0]        err_q, err_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_exp_q, fail_exp_d;
    logic [DATA_W-1:0] fail_act_q, fail_act_d;
    logic [2:0]        fail_elem_q, fail_elem_d;

    logic              run;
    logic              two_op;
    logic              is_read;
    logic              is_write;
    logic              up;
    logic              op_last;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] rd_exp;
    logic [DATA_W-1:0] wr_data;

    // Element decode: M0 w0, M1 r0w1, M2 r1w0, M3 r0w1 (down), M4 r1w0 (down), M5 r0.
    assign run       = (state_q == S_RUN);
    assign two_op    = (elem_q >= 3'd1) && (elem_q <= 3'd4);
    assign is_read   = (elem_q == 3'd5) || (two_op && !phase_q);
    assign is_write  = !is_read;
    assign up        = !((elem_q == 3'd3) || (elem_q == 3'd4));
    assign op_last   = is_write || (elem_q == 3'd5);
    assign last_addr = up ? ADDR_MAX : '0;
    assign rd_exp    = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? ~BG : BG;
    assign wr_data   = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? ~BG : BG;

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        addr_d      = addr_q;
        phase_d     = phase_q;
        done_d      = done_q;
        go_d        = go_q;
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        fail_exp_d  = fail_exp_q;
        fail_act_d  = fail_act_q;
        fail_elem_d = fail_elem_q;
        pipe_vld_d  = run && is_read;
        pipe_exp_d  = rd_exp;
        pipe_addr_d = addr_q;
        pipe_elem_d = elem_q;

        // go_q still high means no earlier mismatch in this run.
        if (pipe_vld_q && (sram.sram_rdata != pipe_exp_q)) begin
            go_d = 1'b0;
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
            if (go_q) begin
                fail_addr_d = pipe_addr_q;
                fail_exp_d  = pipe_exp_q;
                fail_act_d  = sram.sram_rdata;
                fail_elem_d = pipe_elem_q;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_RUN;
                    elem_d      = 3'd0;
                    addr_d      = '0;
                    phase_d     = 1'b0;
                    done_d      = 1'b0;
                    go_d        = 1'b1;
                    err_d       = 8'd0;
                    fail_addr_d = '0;
                    fail_exp_d  = '0;
                    fail_act_d  = '0;
                    fail_elem_d = 3'd0;
                end
            end
            S_RUN: begin
                if (!op_last) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (addr_q == last_addr) begin
                        if (elem_q == 3'd5) begin
                            state_d = S_DRAIN;
                        end else begin
                            elem_d = elem_q + 3'd1;
                            // M3 and M4 walk downwards from the top address.
                            addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_MAX : '0;
                        end
                    end else begin
                        addr_d = up ? (addr_q + ADDR_ONE) : (addr_q - ADDR_ONE);
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            elem_q      <= 3'd0;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            pipe_vld_q  <= 1'b0;
            pipe_exp_q  <= '0;
            pipe_addr_q <= '0;
            pipe_elem_q <= 3'd0;
            done_q      <= 1'b0;
            go_q        <= 1'b1;
            err_q       <= 8'd0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_act_q  <= '0;
            fail_elem_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            phase_q     <= phase_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_exp_q  <= pipe_exp_d;
            pipe_addr_q <= pipe_addr_d;
            pipe_elem_q <= pipe_elem_d;
            done_q      <= done_d;
            go_q        <= go_d;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            fail_exp_q  <= fail_exp_d;
            fail_act_q  <= fail_act_d;
            fail_elem_q <= fail_elem_d;
        end
    end

    assign sram.sram_addr   = run ? addr_q : '0;
    assign sram.sram_we     = run && is_write;
    assign sram.sram_wdata  = (run && is_write) ? wr_data : BG;
    assign sram.bist_active = (state_q == S_RUN) || (state_q == S_DRAIN);

    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = done_q;
    assign go_nogo   = go_q;
    assign fail_addr = fail_addr_q;
    assign fail_exp  = fail_exp_q;
    assign fail_act  = fail_act_q;
    assign fail_elem = fail_elem_q;
    assign err_count = err_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_march_bist_controller.sv
// Bench for march_bist_controller: faulty-SRAM model, March C- reference built from
// element definitions, per-cycle bus scoreboard and end-of-run result checks.
module tb_march_bist_controller;
    localparam int         NOPS = 2560;
    localparam logic [3:0] BG   = 4'h0;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, go_nogo;
    logic [7:0] fail_addr, err_count;
    logic [3:0] fail_exp, fail_act;
    logic [2:0] fail_elem;
    logic [1:0] dbg_state;

    march_bist_if #(.ADDR_W(8), .DATA_W(4)) bus ();

    march_bist_controller #(.ADDR_W(8), .DATA_W(4), .BG(BG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sram      (bus),
        .busy      (busy),
        .done      (done),
        .go_nogo   (go_nogo),
        .fail_addr (fail_addr),
        .fail_exp  (fail_exp),
        .fail_act  (fail_act),
        .fail_elem (fail_elem),
        .err_count (err_count),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- SRAM model with stuck-at faults ----------------
    logic [3:0] mem [256];
    logic [7:0] f_addr = 8'h00;
    logic [3:0] f_set  = 4'h0;
    logic [3:0] f_clr  = 4'h0;
    logic       f_all  = 1'b0;

    function automatic logic [3:0] faulty(input logic [7:0] a, input logic [3:0] d);
        if (f_all || (a == f_addr)) return (d | f_set) & ~f_clr;
        return d;
    endfunction

    always @(posedge clk) begin
        bus.sram_rdata <= faulty(bus.sram_addr, mem[bus.sram_addr]);
        if (bus.sram_we) mem[bus.sram_addr] <= bus.sram_wdata;
    end

    // ---------------- checking helpers ----------------
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference March C- operation list ----------------
    logic       op_rd   [NOPS];
    logic [7:0] op_addr [NOPS];
    logic [3:0] op_data [NOPS];
    logic [2:0] op_elem [NOPS];

    task automatic build_ops();
        int k;
        int a;
        logic [3:0] rexp;
        k = 0;
        for (int i = 0; i < 256; i++) begin
            op_rd[k] = 1'b0; op_addr[k] = 8'(i); op_data[k] = BG; op_elem[k] = 3'd0; k++;
        end
        for (int e = 1; e <= 4; e++) begin
            rexp = (e == 1 || e == 3) ? BG : ~BG;
            for (int i = 0; i < 256; i++) begin
                a = (e <= 2) ? i : 255 - i;
                op_rd[k] = 1'b1; op_addr[k] = 8'(a); op_data[k] = rexp;  op_elem[k] = 3'(e); k++;
                op_rd[k] = 1'b0; op_addr[k] = 8'(a); op_data[k] = ~rexp; op_elem[k] = 3'(e); k++;
            end
        end
        for (int i = 0; i < 256; i++) begin
            op_rd[k] = 1'b1; op_addr[k] = 8'(i); op_data[k] = BG; op_elem[k] = 3'd5; k++;
        end
    endtask

    // ---------------- behavioural result model ----------------
    int         m_cnt;
    logic [7:0] m_err, m_faddr;
    logic [3:0] m_fexp, m_fact;
    logic [2:0] m_felem;
    logic       m_go;

    task automatic model_run();
        logic [3:0] mm [256];
        logic [3:0] act;
        m_cnt = 0; m_faddr = 0; m_fexp = 0; m_fact = 0; m_felem = 0;
        for (int i = 0; i < 256; i++) mm[i] = mem[i];
        for (int k = 0; k < NOPS; k++) begin
            if (!op_rd[k]) begin
                mm[op_addr[k]] = op_data[k];
            end else begin
                act = faulty(op_addr[k], mm[op_addr[k]]);
                if (act != op_data[k]) begin
                    if (m_cnt == 0) begin
                        m_faddr = op_addr[k]; m_fexp = op_data[k]; m_fact = act; m_felem = op_elem[k];
                    end
                    m_cnt++;
                end
            end
        end
        m_err = (m_cnt > 255) ? 8'hFF : m_cnt[7:0];
        m_go  = (m_cnt == 0);
    endtask

    // ---------------- per-cycle bus scoreboard ----------------
    logic [12:0] exp_q [$];
    logic [12:0] exp_op;
    int          we_cnt = 0;

    always @(negedge clk) begin
        if (bus.sram_we) we_cnt++;
        if (exp_q.size() > 0) begin
            exp_op = exp_q.pop_front();
            chk("bus_op", {bus.sram_we, bus.sram_addr, bus.sram_wdata}, exp_op);
            chk("run_flags", {busy, bus.bist_active, done}, 3'b110);
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, ":busy"}, busy, 0);
        chk({tag, ":done"}, done, 0);
        chk({tag, ":go"}, go_nogo, 1);
        chk({tag, ":err"}, err_count, 0);
        chk({tag, ":fail_addr"}, fail_addr, 0);
        chk({tag, ":fail_exp"}, fail_exp, 0);
        chk({tag, ":fail_act"}, fail_act, 0);
        chk({tag, ":fail_elem"}, fail_elem, 0);
        chk({tag, ":sram_bus"}, {bus.sram_we, bus.sram_addr, bus.sram_wdata, bus.bist_active}, 0);
    endtask

    // ---------------- driver: one complete run ----------------
    task automatic run_test(input string tag, input bit glitch, input int reset_at);
        int g_at;
        model_run();
        @(negedge clk);
        chk({tag, ":busy_before_start"}, busy, 0);
        start = 1'b1;
        @(posedge clk);
        we_cnt = 0;
        for (int k = 0; k < NOPS; k++)
            exp_q.push_back({~op_rd[k], op_addr[k], op_rd[k] ? BG : op_data[k]});
        @(negedge clk);
        start = 1'b0;
        chk({tag, ":cleared"}, {done, go_nogo, err_count, fail_addr, fail_elem}, {1'b0, 1'b1, 19'd0});
        g_at = glitch ? $urandom_range(5, NOPS - 10) : -1;
        for (int k = 1; k < NOPS; k++) begin
            @(negedge clk);
            start = (k == g_at);
            if (k == reset_at) begin
                start = 1'b0;
                #2 rst_n = 1'b0;
                #1 chk_reset({tag, ":async_reset"});
                exp_q.delete();
                repeat (3) @(negedge clk);
                chk_reset({tag, ":held_reset"});
                rst_n = 1'b1;
                return;
            end
        end
        start = 1'b0;
        @(negedge clk);
        chk({tag, ":drain"}, {busy, bus.bist_active, done, bus.sram_we}, 4'b1100);
        @(negedge clk);
        chk({tag, ":done_edge"}, {done, busy, bus.bist_active}, 3'b100);
        chk({tag, ":go"}, go_nogo, m_go);
        chk({tag, ":err"}, err_count, m_err);
        chk({tag, ":fail_addr"}, fail_addr, m_faddr);
        chk({tag, ":fail_exp"}, fail_exp, m_fexp);
        chk({tag, ":fail_act"}, fail_act, m_fact);
        chk({tag, ":fail_elem"}, fail_elem, m_felem);
        chk({tag, ":we_cycles"}, we_cnt, 1280);
        repeat (3) @(negedge clk);
        chk({tag, ":done_hold"}, {done, busy, err_count}, {1'b1, 1'b0, m_err});
        chk({tag, ":idle_bus"}, {bus.sram_we, bus.sram_addr, bus.sram_wdata}, {1'b0, 8'h00, BG});
    endtask

    // ---------------- main sequence ----------------
    int         nrd;
    logic [7:0] run1_err;
    logic       run1_go;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 4'($urandom_range(0, 15));
        build_ops();

        nrd = 0;
        for (int k = 0; k < NOPS; k++) if (op_rd[k]) nrd++;
        chk("model_read_count", nrd, 1280);
        chk("model_m3_first", {op_rd[1280], op_addr[1280], op_rd[1281], op_addr[1281]}, {1'b1, 8'hFF, 1'b0, 8'hFF});
        chk("model_m4_last", {op_rd[2303], op_addr[2303], op_data[2303]}, {1'b0, 8'h00, 4'h0});
        chk("model_m5_first", {op_rd[2304], op_addr[2304], op_elem[2304]}, {1'b1, 8'h00, 3'd5});

        repeat (3) @(negedge clk);
        chk_reset("por");
        rst_n = 1'b1;

        // Fault-free run.
        f_set = 4'h0; f_clr = 4'h0; f_all = 1'b0;
        run_test("clean", 1'b0, -1);
        chk("model_clean", {m_err, m_go}, {8'd0, 1'b1});
        run1_err = err_count;
        run1_go  = go_nogo;

        // Bit 2 of 0x3A stuck at 1, start glitch during RUN.
        f_addr = 8'h3A; f_set = 4'h4; f_clr = 4'h0;
        run_test("sa1_3a", 1'b1, -1);
        chk("model_sa1_3a", {m_faddr, m_fexp, m_fact, m_felem, m_err}, {8'h3A, 4'h0, 4'h4, 3'd1, 8'd3});

        // Every cell stuck at zero: counter saturates.
        f_all = 1'b1; f_set = 4'h0; f_clr = 4'hF;
        run_test("all_sa0", 1'b0, -1);
        chk("model_all_sa0", {m_faddr, m_fexp, m_felem, m_err}, {8'h00, 4'hF, 3'd2, 8'hFF});
        chk("model_all_sa0_cnt", m_cnt, 512);

        // Reset mid-test, then reproduce the clean run.
        f_all = 1'b0; f_set = 4'h0; f_clr = 4'h0;
        run_test("midreset", 1'b0, 1000);
        run_test("rerun", 1'b1, -1);
        chk("rerun_matches_run1", {err_count, go_nogo}, {run1_err, run1_go});

        // Randomised single-cell faults.
        for (int r = 0; r < 6; r++) begin
            f_addr = 8'($urandom_range(0, 255));
            f_set  = 4'($urandom_range(0, 15));
            f_clr  = 4'($urandom_range(0, 15)) & ~f_set;
            f_all  = ($urandom_range(0, 7) == 0);
            run_test($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
